// File: rtl/reaction_timer_core.sv
// Reaction-timer trial controller: random pre-GO delay, BCD millisecond count, result/status outputs.
// Optional best-result register enabled by defining REACTION_BEST_EN.
module reaction_timer_core #(
    parameter int TICK_DIV     = 50000,
    parameter int MIN_DELAY_MS = 1000,
    parameter int DELAY_BITS   = 11
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        start,
    input  logic        react,
    output logic        led_go,
    output logic [15:0] bcd,
    output logic [2:0]  status,
    output logic        early,
    output logic        timeout,
    output logic [15:0] best_bcd,
    output logic        best_valid
);

    localparam int PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DELAY_W = $clog2(MIN_DELAY_MS + (1 << DELAY_BITS)) + 1;

    typedef enum logic [2:0] {
        IDLE  = 3'b000,
        WAIT  = 3'b001,
        GO    = 3'b010,
        DONE  = 3'b011,
        EARLY = 3'b100
    } state_t;

    state_t               state_q, state_d;
    logic                 prevStart_q, prevReact_q;
    logic [15:0]          lfsr_q, lfsr_d;
    logic [PRESC_W-1:0]   presc_q, presc_d;
    logic [DELAY_W-1:0]   delay_q, delay_d;
    logic [15:0]          bcd_q, bcd_d;
    logic                 early_q, early_d;
    logic                 timeout_q, timeout_d;
    logic                 startEdge, reactEdge, tick;
    logic [DELAY_W-1:0]   delayLoad;

    // Cascaded decimal increment: a digit only advances when every lower digit wrapped 9->0.
    function automatic logic [15:0] bcdInc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (v[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    assign startEdge = start & ~prevStart_q;
    assign reactEdge = react & ~prevReact_q;
    assign tick      = (presc_q == PRESC_W'(TICK_DIV - 1));
    assign lfsr_d    = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    assign delayLoad = DELAY_W'(MIN_DELAY_MS) + DELAY_W'(lfsr_q[DELAY_BITS-1:0]);

    always_comb begin
        state_d   = state_q;
        delay_d   = delay_q;
        bcd_d     = bcd_q;
        early_d   = early_q;
        timeout_d = timeout_q;
        case (state_q)
            IDLE, DONE, EARLY: begin
                if (startEdge) begin
                    state_d   = WAIT;
                    delay_d   = delayLoad;
                    bcd_d     = 16'h0000;
                    early_d   = 1'b0;
                    timeout_d = 1'b0;
                end
            end
            WAIT: begin
                // A react edge wins over an expiry tick landing on the same edge.
                if (reactEdge) begin
                    state_d = EARLY;
                    early_d = 1'b1;
                end else if (tick) begin
                    delay_d = delay_q - DELAY_W'(1);
                    if (delay_q == DELAY_W'(1)) begin
                        state_d = GO;
                        bcd_d   = 16'h0000;
                    end
                end
            end
            GO: begin
                if (reactEdge) begin
                    state_d = DONE;
                end else if (tick) begin
                    if (bcd_q == 16'h9999) begin
                        state_d   = DONE;
                        timeout_d = 1'b1;
                    end else begin
                        bcd_d = bcdInc(bcd_q);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // Restarting the prescaler on each state entry aligns the first tick to TICK_DIV cycles.
        if (state_d != state_q || tick) begin
            presc_d = '0;
        end else begin
            presc_d = presc_q + PRESC_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q     <= IDLE;
            prevStart_q <= 1'b1;
            prevReact_q <= 1'b1;
            lfsr_q      <= 16'hACE1;
            presc_q     <= '0;
            delay_q     <= '0;
            bcd_q       <= 16'h0000;
            early_q     <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            prevStart_q <= start;
            prevReact_q <= react;
            lfsr_q      <= lfsr_d;
            presc_q     <= presc_d;
            delay_q     <= delay_d;
            bcd_q       <= bcd_d;
            early_q     <= early_d;
            timeout_q   <= timeout_d;
        end
    end

`ifdef REACTION_BEST_EN
    logic [15:0] best_q;
    logic        bestValid_q;
    logic        doneByReact;

    assign doneByReact = (state_q == GO) && reactEdge;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            best_q      <= 16'h9999;
            bestValid_q <= 1'b0;
        end else if (doneByReact && (!bestValid_q || bcd_q < best_q)) begin
            best_q      <= bcd_q;
            bestValid_q <= 1'b1;
        end
    end

    assign best_bcd   = best_q;
    assign best_valid = bestValid_q;
`else
    assign best_bcd   = 16'h9999;
    assign best_valid = 1'b0;
`endif

    assign status  = state_q;
    assign led_go  = (state_q == GO);
    assign bcd     = bcd_q;
    assign early   = early_q;
    assign timeout = timeout_q;

endmodule
